// File: rtl/present_pkg.sv
// present_pkg: PRESENT cipher shared constants, S-box table and control state encoding.
package present_pkg;
    localparam int BLOCK_W = 64;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = 16;
    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: combinational PRESENT 4-bit S-box lookup.
module present_sbox4
    import present_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    output logic [NIB_W-1:0] y
);
    always_comb y = SBOX[x];
endmodule

// File: rtl/present_sbox_layer_serial.sv
// present_sbox_layer_serial: serial PRESENT S-layer, NIB_PER_CYC nibbles per clock.
// Define PRESENT_SBOX_KEYADD_EN to add an rkey port XORed into the state on load.
module present_sbox_layer_serial
    import present_pkg::*;
#(
    parameter int NIB_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PRESENT_SBOX_KEYADD_EN
    input  logic [BLOCK_W-1:0] rkey,
`endif
    input  logic [BLOCK_W-1:0] idat,
    input  logic               ivalid,
    output logic               iready,
    output logic [BLOCK_W-1:0] odat,
    output logic               ovalid,
    input  logic               oready
);
    localparam int STEPS = NIBBLES / NIB_PER_CYC;
    localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam int SW    = NIB_W * NIB_PER_CYC;

    if (NIB_PER_CYC != 1 && NIB_PER_CYC != 2 && NIB_PER_CYC != 4 &&
        NIB_PER_CYC != 8 && NIB_PER_CYC != 16) begin : g_bad_param
        $error("NIB_PER_CYC must be 1, 2, 4, 8 or 16");
    end

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [BLOCK_W-1:0]    st, ld;
    logic [SW-1:0]         sub;
    logic [SW+BLOCK_W-1:0] cat;

    for (genvar i = 0; i < NIB_PER_CYC; i++) begin : g_sbox
        present_sbox4 u_sbox (.x(st[i*NIB_W +: NIB_W]), .y(sub[i*NIB_W +: NIB_W]));
    end

    // Substituted low nibbles go to the top, which is a right rotation of the register.
    assign cat  = {sub, st};
    assign odat = st;

`ifdef PRESENT_SBOX_KEYADD_EN
    assign ld = idat ^ rkey;
`else
    assign ld = idat;
`endif

    always_comb begin
        state_nx = state;
        iready   = 1'b0;
        ovalid   = 1'b0;
        case (state)
            IDLE: begin
                iready = 1'b1;
                if (ivalid) state_nx = BUSY;
            end
            BUSY: if (cnt == CW'(STEPS - 1)) state_nx = DONE;
            DONE: begin
                ovalid = 1'b1;
                if (oready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= '0;
            cnt <= '0;
        end else if (state == IDLE && ivalid) begin
            st  <= ld;
            cnt <= '0;
        end else if (state == BUSY) begin
            st  <= cat[SW+BLOCK_W-1:SW];
            cnt <= cnt + 1'b1;
        end
    end
endmodule
